// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for a DDS core: loads a phase offset, then steps
// the tuning word from f_start to f_stop with a programmable dwell per point.
module dds_sweep_ctrl #(
    parameter int W  = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          repeat_mode,
    input  logic [W-1:0]  phase_init,
    input  logic [W-1:0]  f_start,
    input  logic [W-1:0]  f_stop,
    input  logic [W-1:0]  f_step,
    input  logic [DW-1:0] dwell,
    output logic          Enable,
    output logic          LoadP,
    output logic          LoadF,
    output logic [W-1:0]  FreqPhase,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADP,
        S_LOADF,
        S_DWELL,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [W-1:0]  phase_q;
    logic [W-1:0]  fstart_q;
    logic [W-1:0]  fstop_q;
    logic [W-1:0]  fstep_q;
    logic [W-1:0]  cur_q;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] cnt_q;
    logic          rep_q;

    logic          en_q;
    logic          loadp_q;
    logic          loadf_q;
    logic [W-1:0]  fp_q;
    logic          busy_q;
    logic          done_q;

    logic [W:0]    nxt_d;
    logic          step_ok_d;

    // One extra bit catches the carry so the sweep ends instead of wrapping.
    assign nxt_d     = {1'b0, cur_q} + {1'b0, fstep_q};
    assign step_ok_d = !nxt_d[W]
                     && (nxt_d[W-1:0] <= fstop_q)
                     && (fstep_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            fstart_q <= '0;
            fstop_q  <= '0;
            fstep_q  <= '0;
            cur_q    <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            rep_q    <= 1'b0;
            en_q     <= 1'b0;
            loadp_q  <= 1'b0;
            loadf_q  <= 1'b0;
            fp_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            loadp_q <= 1'b0;
            loadf_q <= 1'b0;
            done_q  <= 1'b0;
            if (stop) begin
                state_q <= S_IDLE;
                en_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            phase_q  <= phase_init;
                            fstart_q <= f_start;
                            fstop_q  <= f_stop;
                            fstep_q  <= f_step;
                            dwell_q  <= (dwell == '0) ? DW'(1) : dwell;
                            rep_q    <= repeat_mode;
                            cur_q    <= f_start;
                            loadp_q  <= 1'b1;
                            fp_q     <= phase_init;
                            en_q     <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= S_LOADP;
                        end
                    end
                    S_LOADP: begin
                        loadf_q <= 1'b1;
                        fp_q    <= cur_q;
                        state_q <= S_LOADF;
                    end
                    S_LOADF: begin
                        cnt_q   <= dwell_q - DW'(1);
                        state_q <= S_DWELL;
                    end
                    S_DWELL: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - DW'(1);
                        end else if (step_ok_d) begin
                            cur_q   <= nxt_d[W-1:0];
                            fp_q    <= nxt_d[W-1:0];
                            loadf_q <= 1'b1;
                            state_q <= S_LOADF;
                        end else if (rep_q) begin
                            cur_q   <= fstart_q;
                            fp_q    <= fstart_q;
                            loadf_q <= 1'b1;
                            state_q <= S_LOADF;
                        end else begin
                            done_q  <= 1'b1;
                            en_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Enable    = en_q;
    assign LoadP     = loadp_q;
    assign LoadF     = loadf_q;
    assign FreqPhase = fp_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed and random sweeps compared
// cycle by cycle against a point-list model of the sweep.
module tb_dds_sweep_ctrl;

    localparam int W  = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          repeat_mode;
    logic [W-1:0]  phase_init;
    logic [W-1:0]  f_start;
    logic [W-1:0]  f_stop;
    logic [W-1:0]  f_step;
    logic [DW-1:0] dwell;
    logic          Enable;
    logic          LoadP;
    logic          LoadF;
    logic [W-1:0]  FreqPhase;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    int           pts[$];
    int           m_phase;
    int           m_P;
    int           m_endc;
    bit           m_rep;
    bit           m_stopped;
    logic [W-1:0] idle_fp;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(.W(W), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .repeat_mode(repeat_mode),
        .phase_init (phase_init),
        .f_start    (f_start),
        .f_stop     (f_stop),
        .f_step     (f_step),
        .dwell      (dwell),
        .Enable     (Enable),
        .LoadP      (LoadP),
        .LoadF      (LoadF),
        .FreqPhase  (FreqPhase),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [W+4:0] obs();
        return {Enable, LoadP, LoadF, busy, done, FreqPhase};
    endfunction

    task automatic check(input string tag, input int c,
                         input logic [W+4:0] e);
        logic [W+4:0] o;
        o = obs();
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, o, e);
        end
    endtask

    function automatic int fp_at(input int c);
        int k;
        if (c == 1) return m_phase;
        k = (c - 2) / m_P;
        if (m_rep) return pts[k % pts.size()];
        if (k >= pts.size()) k = pts.size() - 1;
        return pts[k];
    endfunction

    // Bits: {Enable, LoadP, LoadF, busy, done, FreqPhase}; c counts cycles
    // after the edge that accepted start.
    function automatic logic [W+4:0] model(input int c);
        if (c == 1)
            return {5'b11010, W'(m_phase)};
        if (m_stopped && c > m_endc)
            return {5'b00000, W'(fp_at(m_endc))};
        if (!m_stopped && c >= m_endc)
            return {4'b0000, c == m_endc, W'(fp_at(c))};
        return {2'b10, (c - 2) % m_P == 0, 2'b10, W'(fp_at(c))};
    endfunction

    task automatic scramble();
        phase_init  = W'($urandom);
        f_start     = W'($urandom);
        f_stop      = W'($urandom);
        f_step      = W'($urandom);
        dwell       = DW'($urandom);
        repeat_mode = 1'($urandom);
    endtask

    task automatic run_sweep(input string tag, input int ph, input int fs,
                             input int fe, input int st, input int dw,
                             input bit rep, input int stop_c,
                             input int rst_c);
        int p;
        int nx;
        int last;
        logic [W+4:0] e;
        pts.delete();
        p = fs;
        pts.push_back(p);
        if (st != 0) begin
            while (1) begin
                nx = p + st;
                if (nx > fe || nx > 65535) break;
                pts.push_back(nx);
                p = nx;
            end
        end
        m_P       = ((dw == 0) ? 1 : dw) + 1;
        m_phase   = ph;
        m_rep     = rep;
        m_stopped = (stop_c != 0);
        m_endc    = m_stopped ? stop_c : 2 + pts.size() * m_P;
        last      = (rst_c != 0) ? rst_c : m_endc + 2;

        phase_init  = W'(ph);
        f_start     = W'(fs);
        f_stop      = W'(fe);
        f_step      = W'(st);
        dwell       = DW'(dw);
        repeat_mode = rep;
        start       = 1'b1;
        stop        = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            e = model(c);
            check(tag, c, e);
            start = (rst_c == 0 && c <= m_endc) ? 1'($urandom) : 1'b0;
            stop  = (c == stop_c);
            scramble();
            if (c == last) idle_fp = e[W-1:0];
            if (c == rst_c) begin
                #2 rst = 1'b1;
                #1 check({tag, "_async_rst"}, c, '0);
                @(negedge clk);
                check({tag, "_in_rst"}, c, '0);
                rst = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check({tag, "_post_rst"}, i, '0);
                end
                idle_fp = '0;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int fs;
        int fe;
        int st;
        int dw;
        bit rep;
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        scramble();
        repeat (2) @(negedge clk);
        check("reset", 0, '0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 0, '0);
        idle_fp = '0;

        run_sweep("single", 16'h0040, 100, 250, 50, 3, 1'b0, 0, 0);
        run_sweep("repeat", 16'h0040, 100, 250, 50, 3, 1'b1, 27, 0);
        run_sweep("carry", 16'h1234, 16'hFFF0, 16'hFFFF, 16'h0020,
                  0, 1'b0, 0, 0);
        run_sweep("start_gt_stop", 16'h0001, 500, 100, 10, 2, 1'b0, 0, 0);
        run_sweep("step_zero", 16'h0002, 500, 1000, 0, 1, 1'b0, 0, 0);
        run_sweep("rep_one_point", 16'h0003, 500, 100, 10, 1, 1'b1, 9, 0);
        run_sweep("rst_mid", 16'h0040, 100, 250, 50, 3, 1'b0, 0, 8);

        phase_init = 16'h0055;
        start      = 1'b1;
        stop       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("start_and_stop", i, {5'b00000, idle_fp});
            start = 1'b0;
            stop  = 1'b0;
        end

        for (int r = 0; r < 10; r++) begin
            fs  = int'($urandom_range(0, 65535));
            st  = ($urandom_range(0, 4) == 0) ? 0
                : int'($urandom_range(100, 400));
            fe  = fs + int'($urandom_range(0, 2000));
            if (fe > 65535) fe = 65535;
            if ($urandom_range(0, 3) == 0) fe = int'($urandom_range(0, 65535));
            dw  = int'($urandom_range(0, 5));
            rep = 1'($urandom);
            run_sweep("random", int'($urandom_range(0, 65535)), fs, fe, st,
                      dw, rep, rep ? int'($urandom_range(2, 40)) : 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
